// File: rtl/alu_ctrl_queue_if.sv
// Decode-to-execute bus for alu_ctrl_queue: instruction/ALUOp input handshake,
// flush, and the decoded head entry presented to the execute stage.
interface alu_ctrl_queue_if #(
    parameter int OP_W      = 4,
    parameter int ILL_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instruction;
    logic [1:0]           ALUOp;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [OP_W-1:0]      alu_op;
    logic                 set_flags;
    logic                 imm_sel;
    logic [5:0]           shift_amt;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    modport master (
        output in_valid, instruction, ALUOp, flush, out_ready,
        input  in_ready, out_valid, alu_op, set_flags, imm_sel, shift_amt,
               illegal, ill_count
    );

    modport slave (
        input  in_valid, instruction, ALUOp, flush, out_ready,
        output in_ready, out_valid, alu_op, set_flags, imm_sel, shift_amt,
               illegal, ill_count
    );
endinterface

// File: rtl/alu_ctrl_queue.sv
// Registered ALU control decoder: decodes instruction+ALUOp on acceptance and
// queues the control fields in a DEPTH-entry FIFO with a saturating illegal counter.
module alu_ctrl_queue #(
    parameter int OP_W      = 4,
    parameter int DEPTH     = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_ctrl_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_MOVZ   = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_ORR    = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_PASS_B = 4'b0111;

    typedef struct packed {
        logic [3:0] op;
        logic       set_flags;
        logic       imm_sel;
        logic [5:0] shift_amt;
        logic       illegal;
    } entry_t;

    entry_t               mem [DEPTH];
    entry_t               decoded;
    entry_t               head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [ILL_CNT_W-1:0] ill_cnt;
    logic                 push;
    logic                 pop;
    logic                 in_ready_int;
    logic                 out_valid_int;
    logic                 unused_ins_bits;

    // Low instruction bits carry operands, not opcode; only the upper fields decode.
    assign unused_ins_bits = ^bus.instruction[20:0];

    always_comb begin
        decoded = '0;
        unique case (bus.ALUOp)
            2'b00: begin
                decoded.op      = OP_ADD;
                decoded.imm_sel = 1'b1;
            end
            2'b01: begin
                if (bus.instruction[31:24] == 8'b10110100 ||
                    bus.instruction[31:24] == 8'b10110101)
                    decoded.op = OP_PASS_B;
                else
                    decoded.illegal = 1'b1;
            end
            2'b10: begin
                if (bus.instruction[31:23] == 9'b110100101) begin
                    decoded.op        = OP_MOVZ;
                    decoded.imm_sel   = 1'b1;
                    decoded.shift_amt = {bus.instruction[22:21], 4'b0000};
                end else if (bus.instruction[31:24] == 8'b11101011) begin
                    decoded.op        = OP_SUB;
                    decoded.set_flags = 1'b1;
                end else if (bus.instruction[31:23] == 9'b110100010) begin
                    decoded.op      = OP_SUB;
                    decoded.imm_sel = 1'b1;
                end else if (bus.instruction[31:23] == 9'b100100010) begin
                    decoded.op      = OP_ADD;
                    decoded.imm_sel = 1'b1;
                end else if (bus.instruction[31:24] == 8'b10001011) begin
                    decoded.op = OP_ADD;
                end else if (bus.instruction[31:24] == 8'b10001010) begin
                    decoded.op = OP_AND;
                end else if (bus.instruction[31:24] == 8'b10101010) begin
                    decoded.op = OP_ORR;
                end else begin
                    decoded.illegal = 1'b1;
                end
            end
            default: decoded.illegal = 1'b1;
        endcase
    end

    // No full-bypass: a full queue refuses input even if the head is leaving.
    assign in_ready_int  = !rst && (count < DEPTH_C);
    assign out_valid_int = !rst && (count != '0);
    assign push          = bus.in_valid && in_ready_int;
    assign pop           = out_valid_int && bus.out_ready;
    assign head          = out_valid_int ? mem[rd_ptr] : '0;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.alu_op    = OP_W'(head.op);
    assign bus.set_flags = head.set_flags;
    assign bus.imm_sel   = head.imm_sel;
    assign bus.shift_amt = head.shift_amt;
    assign bus.illegal   = head.illegal;
    assign bus.ill_count = ill_cnt;

    always_ff @(posedge clk) begin
        if (push && !bus.flush)
            mem[wr_ptr] <= decoded;
    end

    // Illegal pushes are counted even when a same-cycle flush discards them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ill_cnt <= '0;
        end else begin
            if (push && decoded.illegal && ill_cnt != '1)
                ill_cnt <= ill_cnt + ILL_CNT_W'(1);
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_queue.sv
// Scoreboard bench for alu_ctrl_queue: directed scenarios then random traffic,
// checked against a table-driven decode model and an occupancy/illegal-count model.
module tb_alu_ctrl_queue;
    localparam int OP_W      = 4;
    localparam int DEPTH     = 2;
    localparam int ILL_CNT_W = 8;
    localparam int ILL_MAX   = (1 << ILL_CNT_W) - 1;

    typedef struct {
        int op;
        bit sf;
        bit imm;
        int sh;
        bit ill;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   model_ill;
    int   pop_pending;
    int   check_count;
    int   pass_count;

    alu_ctrl_queue_if #(.OP_W(OP_W), .ILL_CNT_W(ILL_CNT_W)) bus ();

    alu_ctrl_queue #(.OP_W(OP_W), .DEPTH(DEPTH), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decode table written from the opcode rules, using numeric opcode fields.
    function automatic exp_t ref_decode(input bit [31:0] ins, input bit [1:0] cls);
        exp_t r;
        int top8;
        int top9;
        top8 = int'(ins >> 24);
        top9 = int'(ins >> 23);
        r = '{op: 0, sf: 0, imm: 0, sh: 0, ill: 0};
        case (cls)
            2'd0: begin r.op = 2; r.imm = 1; end
            2'd1: begin
                if (top8 == 'hB4 || top8 == 'hB5) r.op = 7;
                else r.ill = 1;
            end
            2'd2: begin
                if (top9 == 'h1A5) begin
                    r.op = 1; r.imm = 1; r.sh = int'((ins >> 21) & 3) * 16;
                end
                else if (top8 == 'hEB)  begin r.op = 6; r.sf = 1; end
                else if (top9 == 'h1A2) begin r.op = 6; r.imm = 1; end
                else if (top9 == 'h122) begin r.op = 2; r.imm = 1; end
                else if (top8 == 'h8B)  r.op = 2;
                else if (top8 == 'h8A)  r.op = 0;
                else if (top8 == 'hAA)  r.op = 3;
                else r.ill = 1;
            end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic bit [31:0] rand_instr();
        bit [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[31:23] = 9'h1A5;
            1: w[31:24] = 8'hEB;
            2: w[31:23] = 9'h1A2;
            3: w[31:23] = 9'h122;
            4: w[31:24] = 8'h8B;
            5: w[31:24] = 8'h8A;
            6: w[31:24] = 8'hAA;
            7: w[31:24] = 8'hB4;
            8: w[31:24] = 8'hB5;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic apply_stimulus(input bit v, input bit [31:0] ins, input bit [1:0] cls,
                                  input bit fl, input bit ordy);
        bus.in_valid    = v;
        bus.instruction = ins;
        bus.ALUOp       = cls;
        bus.flush       = fl;
        bus.out_ready   = ordy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: acceptance from model occupancy, applied on the clock edge.
    always @(posedge clk) begin
        int occ;
        exp_t e;
        occ = exp_q.size() + pop_pending;
        pop_pending = 0;
        if (rst) begin
            exp_q.delete();
            model_ill = 0;
        end else begin
            if (bus.in_valid && occ < DEPTH) begin
                e = ref_decode(bus.instruction, bus.ALUOp);
                if (e.ill && model_ill < ILL_MAX) model_ill++;
                if (!bus.flush) exp_q.push_back(e);
            end
            if (bus.flush) exp_q.delete();
        end
    end

    // Monitor: mid-cycle comparison of the presented head and status outputs.
    always @(negedge clk) begin
        bit   exp_valid;
        exp_t e;
        exp_valid = !rst && exp_q.size() != 0;
        check_output("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check_output("in_ready", 32'(bus.in_ready), 32'(!rst && exp_q.size() < DEPTH));
        check_output("ill_count", 32'(bus.ill_count), 32'(model_ill));
        if (exp_valid) begin
            e = exp_q[0];
            check_output("alu_op", 32'(bus.alu_op), 32'(e.op));
            check_output("set_flags", 32'(bus.set_flags), 32'(e.sf));
            check_output("imm_sel", 32'(bus.imm_sel), 32'(e.imm));
            check_output("shift_amt", 32'(bus.shift_amt), 32'(e.sh));
            check_output("illegal", 32'(bus.illegal), 32'(e.ill));
            if (bus.out_ready) begin
                void'(exp_q.pop_front());
                pop_pending = 1;
            end
        end else begin
            check_output("idle_payload",
                         32'({bus.alu_op, bus.set_flags, bus.imm_sel, bus.shift_amt, bus.illegal}), 32'd0);
        end
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        model_ill   = 0;
        pop_pending = 0;
        rst = 1'b1;
        bus.in_valid = 0; bus.instruction = '0; bus.ALUOp = '0; bus.flush = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single MOVZ hw=01 through an always-ready consumer
        apply_stimulus(1, 32'hD2A00020, 2'b10, 0, 1);
        repeat (2) apply_stimulus(0, 0, 2'b00, 0, 1);

        // CMP then CBZ back-to-back
        apply_stimulus(1, 32'hEB02003F, 2'b10, 0, 1);
        apply_stimulus(1, 32'hB4000040, 2'b01, 0, 1);
        repeat (2) apply_stimulus(0, 0, 2'b00, 0, 1);

        // Back-pressure: third push refused while full, then drain
        apply_stimulus(1, 32'h8B020020, 2'b10, 0, 0);
        apply_stimulus(1, 32'hAA020020, 2'b10, 0, 0);
        apply_stimulus(1, 32'h8A020020, 2'b10, 0, 0);
        repeat (4) apply_stimulus(0, 0, 2'b00, 0, 1);

        // Flush with two queued and a same-cycle push
        apply_stimulus(1, 32'h91000421, 2'b10, 0, 0);
        apply_stimulus(1, 32'hF8400020, 2'b00, 0, 0);
        apply_stimulus(0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 32'hD1000421, 2'b10, 1, 0);
        repeat (2) apply_stimulus(0, 0, 2'b00, 0, 1);

        // Illegal counter saturation
        for (int i = 0; i < 300; i++) apply_stimulus(1, $urandom, 2'b11, 0, 1);
        repeat (2) apply_stimulus(0, 0, 2'b00, 0, 1);

        // Reset mid-operation with two entries queued and ill_count=5
        rst = 1'b1;
        apply_stimulus(0, 0, 2'b00, 0, 1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) apply_stimulus(1, 32'hFFFFFFFF, 2'b01, 0, 1);
        apply_stimulus(0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 32'h8B020020, 2'b10, 0, 0);
        apply_stimulus(1, 32'hB5000040, 2'b01, 0, 0);
        rst = 1'b1;
        apply_stimulus(0, 0, 2'b00, 0, 1);
        rst = 1'b0;
        repeat (2) apply_stimulus(0, 0, 2'b00, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), rand_instr(), 2'($urandom),
                           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end
        repeat (4) apply_stimulus(0, 0, 2'b00, 0, 1);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_queue.md
Name: alu_ctrl_queue

Overview:
- Registered, parametrised successor to the combinational ALU control decoder in the CPU decode path.
- Decodes each accepted instruction together with its 2-bit ALUOp class into ALU control fields:
  - ALU operation code
  - flag-set enable
  - immediate select
  - MOVZ shift amount
  - illegal indication
- Decoded entries are held in a DEPTH-entry FIFO and presented to the execute stage over a valid/ready handshake.
- Adds back-pressure, flush, and a saturating illegal-instruction counter.

Parameters:
- OP_W, 4, width of alu_op. Must be >= 4; codes are zero-extended.
- DEPTH, 2, number of FIFO entries. Power of two, >= 2.
- ILL_CNT_W, 8, width of the saturating illegal counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  instruction/ALUOp valid from decode
- in_ready  out  1  block can accept an entry
- instruction  in  32  A64 instruction word
- ALUOp  in  2  class: 00 load/store, 01 branch, 10 data-processing, 11 reserved
- flush  in  1  discard all queued entries (branch mispredict / exception)
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage consumes head
- alu_op  out  OP_W  ALU operation code of head
- set_flags  out  1  head updates NZCV
- imm_sel  out  1  ALU B operand is the immediate
- shift_amt  out  6  MOVZ left shift, hw*16 (0/16/32/48)
- illegal  out  1  head instruction is not decodable in its class
- ill_count  out  ILL_CNT_W  saturating count of illegal entries accepted

Behaviour:
- Decode, evaluated on the input at acceptance. Bit fields are instruction[31:k].
- Default for every class: set_flags=0, imm_sel=0, shift_amt=0, illegal=0.
- ALUOp=00: alu_op=0010 (ADD, address), imm_sel=1.
- ALUOp=01:
  - [31:24]=10110100 (CBZ) or 10110101 (CBNZ): alu_op=0111 (PASS_B).
  - Anything else: alu_op=0000, illegal=1.
- ALUOp=10, priority top-down:
  - [31:23]=110100101 MOVZ: alu_op=0001, imm_sel=1, shift_amt={instruction[22:21],4'b0000}.
  - [31:24]=11101011 SUBS/CMP: alu_op=0110, set_flags=1.
  - [31:23]=110100010 SUBI: alu_op=0110, imm_sel=1.
  - [31:23]=100100010 ADDI: alu_op=0010, imm_sel=1.
  - [31:24]=10001011 ADD: alu_op=0010.
  - [31:24]=10001010 AND: alu_op=0000.
  - [31:24]=10101010 ORR: alu_op=0011.
  - Anything else: alu_op=0000, illegal=1.
- ALUOp=11: alu_op=0000, illegal=1.
- Queue:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = !rst && (count < DEPTH). There is no full-bypass: when full, in_ready=0 even if out_ready=1.
  - Simultaneous push and pop (not full, not empty): count unchanged, order preserved.
  - Latency: an entry pushed in cycle N is visible with out_valid=1 in cycle N+1 at the earliest. There is no combinational in-to-out path.
  - Output fields are the head entry. When out_valid=0, all payload outputs are driven 0.
  - Read/write pointers use log2(DEPTH) bits and wrap naturally. count uses log2(DEPTH)+1 bits.
- Flush:
  - Next cycle: count=0, pointers=0, out_valid=0.
  - A push in the flush cycle is discarded. A pop in the flush cycle has no additional effect.
  - ill_count is not cleared by flush.
- ill_count:
  - Increments by 1 on each accepted push with illegal=1, including pushes discarded by flush.
  - Saturates at all-ones; no wrap.
- Reset, while rst is high and on the following cycle:
  - out_valid=0, in_ready=0 (while rst high), count=0, pointers=0, ill_count=0, all payload outputs 0.
  - Reset asserted mid-operation drops all entries.
  - in_ready=1 in the first cycle after rst deasserts.

Test Plan:
- Reset, then push 0xD2A00020 (MOVZ, hw=01) with ALUOp=10, out_ready=1 -> next cycle out_valid=1, alu_op=0001, imm_sel=1, shift_amt=16, illegal=0; entry popped, out_valid=0 after.
- Push 0xEB02003F (CMP) then 0xB4000040 (CBZ, ALUOp=01) back-to-back -> in-order outputs: {0110, set_flags=1}, then {0111, set_flags=0}.
- Hold out_ready=0, push 3 entries with DEPTH=2 -> in_ready=0 after the 2nd push, 3rd not accepted. Raise out_ready -> entries drain in order, in_ready returns 1 the cycle after the first pop.
- Queue 2 entries, assert flush together with a new push -> next cycle out_valid=0, count=0, and the pushed entry never appears.
- Push 300 entries with ALUOp=11 and ILL_CNT_W=8 -> each output has illegal=1, alu_op=0000; ill_count saturates at 255.
- Assert rst with 2 entries queued and ill_count=5 -> following cycle out_valid=0, ill_count=0, in_ready=0 during rst, in_ready=1 the cycle after release.
